// File: rtl/lut_serial_loader_if.sv
// Parallel-load handshake and serial LUT pins between the upstream programmer
// and the serial-load LUT loader.
interface lut_serial_loader_if #(
  parameter int ENTRIES = 16,
  parameter int WIDTH   = 4
);
  localparam int N = ENTRIES * WIDTH;

  logic         start;
  logic [N-1:0] image;
  logic         busy;
  logic         done;
  logic         sd;
  logic         sclk;
  logic         scs_n;

  modport master (
    output start, image,
    input  busy, done, sd, sclk, scs_n
  );

  modport slave (
    input  start, image,
    output busy, done, sd, sclk, scs_n
  );
endinterface

// File: rtl/lut_serial_loader.sv
// Serialises a parallel LUT image MSB first onto registered sd/sclk/scs_n pins,
// with CLK_DIV-cycle sclk phases and a CLK_DIV-cycle hold tail after the last edge.
module lut_serial_loader #(
  parameter int ENTRIES = 16,
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 1
) (
  input logic               clk,
  input logic               rst_n,
  lut_serial_loader_if.slave bus
);
  localparam int N  = ENTRIES * WIDTH;
  localparam int BW = $clog2(N + 1);
  localparam int PW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic         sd_q, sd_d;
  logic         sclk_q, sclk_d;
  logic         scs_n_q, scs_n_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         phase_last;
  logic         last_bit;

  assign phase_last = (phase_q == PW'(CLK_DIV - 1));
  assign last_bit   = (bitcnt_q == BW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      phase_q  <= '0;
      sd_q     <= 1'b0;
      sclk_q   <= 1'b0;
      scs_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      sd_q     <= sd_d;
      sclk_q   <= sclk_d;
      scs_n_q  <= scs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
    // The shift register is pure data; a fresh image is always latched on accept.
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOW;
      LOW:     if (phase_last) state_d = HIGH;
      HIGH:    if (phase_last) state_d = last_bit ? TAIL : LOW;
      TAIL:    if (phase_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    phase_d  = '0;
    sd_d     = sd_q;
    sclk_d   = sclk_q;
    scs_n_d  = scs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sd_d    = 1'b0;
        sclk_d  = 1'b0;
        scs_n_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.start) begin
          shreg_d  = bus.image;
          bitcnt_d = '0;
          sd_d     = bus.image[N-1];
          scs_n_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      LOW: begin
        if (phase_last) sclk_d = 1'b1;
        else            phase_d = phase_q + PW'(1);
      end
      HIGH: begin
        if (phase_last) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q + BW'(1);
          sclk_d   = 1'b0;
          // sd only moves on the falling edge; it holds the last bit through TAIL.
          if (!last_bit) sd_d = shreg_q[N-2];
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      TAIL: begin
        if (phase_last) begin
          scs_n_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sd_d    = 1'b0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        sd_d    = 1'b0;
        sclk_d  = 1'b0;
        scs_n_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.sd    = sd_q;
  assign bus.sclk  = sclk_q;
  assign bus.scs_n = scs_n_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_lut_serial_loader.sv
// Bench for lut_serial_loader: two loaders (CLK_DIV 1 and 3) each feeding a
// behavioural serial LUT that captures sd on every sclk rise.
module tb_lut_serial_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lut_serial_loader_if #(.ENTRIES(16), .WIDTH(4)) bus1 ();
  lut_serial_loader_if #(.ENTRIES(16), .WIDTH(4)) bus3 ();

  lut_serial_loader #(.ENTRIES(16), .WIDTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  lut_serial_loader #(.ENTRIES(16), .WIDTH(4), .CLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  logic [1:0] sclk_w, sd_w, cs_w, busy_w, done_w;
  assign sclk_w = {bus3.sclk, bus1.sclk};
  assign sd_w   = {bus3.sd, bus1.sd};
  assign cs_w   = {bus3.scs_n, bus1.scs_n};
  assign busy_w = {bus3.busy, bus1.busy};
  assign done_w = {bus3.done, bus1.done};

  // Behavioural LUT plus pin-timing observers, sampled 2 time units after each edge.
  logic [63:0] lut[2] = '{64'h0, 64'h0};
  logic prev_sclk[2] = '{1'b0, 1'b0};
  logic prev_sd[2]   = '{1'b0, 1'b0};
  int cyc = 0;
  int rises[2] = '{0, 0};
  int busy_cyc[2] = '{0, 0};
  int done_cnt[2] = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int done_prev_cyc[2] = '{0, 0};
  int since_sd[2] = '{1000, 1000};
  int since_rise[2] = '{1000, 1000};
  int cs_viol[2] = '{0, 0};
  int setup_viol[2] = '{0, 0};
  int hold_viol[2] = '{0, 0};
  int period_bad[2] = '{0, 0};
  int high_bad[2] = '{0, 0};
  int fr_rises[2] = '{0, 0};
  int last_rise_cyc[2] = '{0, 0};
  int cs_run[2] = '{0, 0};
  int last_cs_run[2] = '{0, 0};

  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      int div;
      div = (g == 0) ? 1 : 3;
      since_sd[g]++;
      since_rise[g]++;
      if (sclk_w[g] === 1'b1 && prev_sclk[g] === 1'b0) begin
        rises[g]++;
        lut[g] = {lut[g][62:0], sd_w[g]};
        if (cs_w[g] !== 1'b0) cs_viol[g]++;
        if (since_sd[g] < div) setup_viol[g]++;
        if (fr_rises[g] > 0 && (cyc - last_rise_cyc[g]) != 2 * div) period_bad[g]++;
        fr_rises[g]++;
        last_rise_cyc[g] = cyc;
        since_rise[g] = 0;
      end
      if (sclk_w[g] === 1'b0 && prev_sclk[g] === 1'b1 && (cyc - last_rise_cyc[g]) != div)
        high_bad[g]++;
      if (sd_w[g] !== prev_sd[g]) begin
        if (since_rise[g] < div) hold_viol[g]++;
        since_sd[g] = 0;
      end
      if (cs_w[g] === 1'b1) begin
        cs_run[g]++;
        fr_rises[g] = 0;
      end else begin
        if (cs_run[g] > 0) last_cs_run[g] = cs_run[g];
        cs_run[g] = 0;
      end
      if (busy_w[g] === 1'b1) busy_cyc[g]++;
      if (done_w[g] === 1'b1) begin
        done_cnt[g]++;
        done_prev_cyc[g] = done_cyc[g];
        done_cyc[g] = cyc;
      end
      prev_sclk[g] = sclk_w[g];
      prev_sd[g]   = sd_w[g];
    end
  end

  // Reference rule: entry e of the loaded table is image bits [e*4 +: 4].
  function automatic logic [3:0] entry_of(input logic [63:0] img, input int e);
    logic [63:0] t;
    t = img >> (e * 4);
    return t[3:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive(input int g, input logic st, input logic [63:0] img);
    if (g == 0) begin bus1.start = st; bus1.image = img; end
    else        begin bus3.start = st; bus3.image = img; end
  endtask

  task automatic kick(input int g, input logic [63:0] img);
    @(negedge clk);
    drive(g, 1'b1, img);
    @(posedge clk);
    @(negedge clk);
    drive(g, 1'b0, img);
  endtask

  task automatic wait_done(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt[g] >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rises[g] >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int r0, r1;
    r0 = rises[0];
    r1 = rises[1];
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus1.scs_n, bus1.sclk, bus1.sd, bus1.busy, bus1.done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_d1: got %b, expected 10000",
               {bus1.scs_n, bus1.sclk, bus1.sd, bus1.busy, bus1.done});
    end
    n_checks++;
    if ({bus3.scs_n, bus3.sclk, bus3.sd, bus3.busy, bus3.done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_d3: got %b, expected 10000",
               {bus3.scs_n, bus3.sclk, bus3.sd, bus3.busy, bus3.done});
    end
    n_checks++;
    if ((rises[0] - r0) + (rises[1] - r1) !== 0) begin
      n_fail++;
      $display("FAIL reset_sclk_edges: got %0d, expected 0", (rises[0] - r0) + (rises[1] - r1));
    end
  endtask

  task automatic test_basic_load;
    logic [63:0] img;
    int r0, b0, d0;
    bit ok;
    img = 64'hFEDCBA9876543210;
    @(negedge clk);
    r0 = rises[0]; b0 = busy_cyc[0]; d0 = done_cnt[0];
    drive(0, 1'b1, img);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'h0);
    n_checks++;
    if ({bus1.scs_n, bus1.busy, bus1.sd, bus1.sclk} !== {1'b0, 1'b1, img[63], 1'b0}) begin
      n_fail++;
      $display("FAIL first_edge: got %b, expected %b", {bus1.scs_n, bus1.busy, bus1.sd, bus1.sclk},
               {1'b0, 1'b1, img[63], 1'b0});
    end
    wait_done(0, d0 + 1, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done, expected one"); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (rises[0] - r0 !== 64) begin
      n_fail++; $display("FAIL basic_rises: got %0d, expected 64", rises[0] - r0);
    end
    n_checks++;
    if (busy_cyc[0] - b0 !== 129) begin
      n_fail++; $display("FAIL basic_busy: got %0d, expected 129", busy_cyc[0] - b0);
    end
    n_checks++;
    if (done_cnt[0] - d0 !== 1) begin
      n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt[0] - d0);
    end
    for (int e = 0; e < 16; e++) begin
      n_checks++;
      if (lut[0][e*4 +: 4] !== 4'(e)) begin
        n_fail++; $display("FAIL basic_sel%0d: got %0h, expected %0h", e, lut[0][e*4 +: 4], e);
      end
    end
  endtask

  task automatic test_divided_clock;
    int r0, b0, d0;
    bit ok;
    r0 = rises[1]; b0 = busy_cyc[1]; d0 = done_cnt[1];
    kick(1, 64'h0123456789ABCDEF);
    wait_done(1, d0 + 1, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL div_done_timeout: got no done, expected one"); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (rises[1] - r0 !== 64) begin
      n_fail++; $display("FAIL div_rises: got %0d, expected 64", rises[1] - r0);
    end
    n_checks++;
    if (busy_cyc[1] - b0 !== 387) begin
      n_fail++; $display("FAIL div_busy: got %0d, expected 387", busy_cyc[1] - b0);
    end
    n_checks++;
    if (period_bad[1] !== 0 || high_bad[1] !== 0) begin
      n_fail++; $display("FAIL div_sclk_shape: got period_bad %0d high_bad %0d, expected 0 0",
                         period_bad[1], high_bad[1]);
    end
    n_checks++;
    if (setup_viol[1] !== 0 || hold_viol[1] !== 0) begin
      n_fail++; $display("FAIL div_sd_stability: got setup %0d hold %0d, expected 0 0",
                         setup_viol[1], hold_viol[1]);
    end
    for (int e = 0; e < 16; e++) begin
      n_checks++;
      if (lut[1][e*4 +: 4] !== 4'(15 - e)) begin
        n_fail++; $display("FAIL div_sel%0d: got %0h, expected %0h", e, lut[1][e*4 +: 4], 15 - e);
      end
    end
  endtask

  task automatic test_random_images;
    logic [63:0] img;
    int d0, bad;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      img = rand64();
      d0 = done_cnt[0];
      kick(0, img);
      wait_done(0, d0 + 1, 400, ok);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int e = 0; e < 16; e++)
        if (lut[0][e*4 +: 4] !== entry_of(img, e)) bad++;
      n_checks++;
      if (!ok || bad != 0) begin
        n_fail++; $display("FAIL random_%0d: got table %h (%0d bad, done %0d), expected %h",
                           it, lut[0], bad, ok, img);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [63:0] a, b;
    int r0, d0, bad;
    bit ok;
    a = rand64();
    b = ~a;
    r0 = rises[0]; d0 = done_cnt[0];
    kick(0, a);
    wait_rises(0, r0 + 10, 100, ok);
    drive(0, 1'b1, b);
    @(negedge clk);
    drive(0, 1'b0, b);
    wait_done(0, d0 + 1, 400, ok);
    repeat (6) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt[0] - d0 !== 1) begin
      n_fail++; $display("FAIL busy_start_done: got %0d dones, expected 1", done_cnt[0] - d0);
    end
    n_checks++;
    if (rises[0] - r0 !== 64) begin
      n_fail++; $display("FAIL busy_start_rises: got %0d, expected 64", rises[0] - r0);
    end
    bad = 0;
    for (int e = 0; e < 16; e++)
      if (lut[0][e*4 +: 4] !== entry_of(a, e)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL busy_start_table: got %h, expected %h", lut[0], a);
    end
  endtask

  task automatic test_reset_mid_frame;
    int r0, d0, bad;
    bit ok;
    r0 = rises[0]; d0 = done_cnt[0];
    kick(0, rand64());
    wait_rises(0, r0 + 20, 100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_reach_bit20: got timeout, expected 20 rises"); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus1.scs_n, bus1.sclk, bus1.sd, bus1.busy, bus1.done} !== 5'b10000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b, expected 10000",
                         {bus1.scs_n, bus1.sclk, bus1.sd, bus1.busy, bus1.done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[0] !== d0 || bus1.busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_resume: got done %0d busy %b, expected %0d 0",
                         done_cnt[0], bus1.busy, d0);
    end
    kick(0, 64'h5555555555555555);
    wait_done(0, d0 + 1, 400, ok);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int e = 0; e < 16; e++)
      if (lut[0][e*4 +: 4] !== 4'h5) bad++;
    n_checks++;
    if (!ok || bad != 0) begin
      n_fail++; $display("FAIL midreset_reload: got %h, expected 5555555555555555", lut[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    int r0, d0, bad;
    bit ok;
    a = rand64();
    b = rand64();
    r0 = rises[0]; d0 = done_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, a);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, b);
    wait_done(0, d0 + 1, 400, ok);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, b);
    n_checks++;
    if (last_cs_run[0] !== 1) begin
      n_fail++; $display("FAIL b2b_cs_gap: got %0d, expected 1", last_cs_run[0]);
    end
    wait_done(0, d0 + 2, 400, ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt[0] - d0 !== 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt[0] - d0);
    end
    n_checks++;
    if (done_cyc[0] - done_prev_cyc[0] !== 130) begin
      n_fail++; $display("FAIL b2b_done_gap: got %0d, expected 130", done_cyc[0] - done_prev_cyc[0]);
    end
    n_checks++;
    if (rises[0] - r0 !== 128) begin
      n_fail++; $display("FAIL b2b_rises: got %0d, expected 128", rises[0] - r0);
    end
    bad = 0;
    for (int e = 0; e < 16; e++)
      if (lut[0][e*4 +: 4] !== entry_of(b, e)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_table: got %h, expected %h", lut[0], b);
    end
  endtask

  task automatic test_pin_rules;
    n_checks++;
    if (cs_viol[0] !== 0 || cs_viol[1] !== 0) begin
      n_fail++; $display("FAIL sclk_rise_with_cs_high: got %0d/%0d, expected 0/0", cs_viol[0], cs_viol[1]);
    end
    n_checks++;
    if (setup_viol[0] !== 0 || hold_viol[0] !== 0 || period_bad[0] !== 0) begin
      n_fail++; $display("FAIL d1_sd_timing: got setup %0d hold %0d period %0d, expected 0 0 0",
                         setup_viol[0], hold_viol[0], period_bad[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.start = 1'b0; bus1.image = '0;
    bus3.start = 1'b0; bus3.image = '0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic_load();
    test_divided_clock();
    test_random_images();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_pin_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
